// File: rtl/motor_ramp_ctrl.sv
// Purpose : H-bridge direction and pulse-width ramp controller with a dwell on reversal and an emergency stop.
// Latency : a command is accepted in one cycle; pulse_width moves at most RAMP_STEP per tick (one tick every TICK_DIV cycles).
// Backpress: cmd_ready is high only in IDLE with estop low; commands offered while busy are dropped, not queued.
//
// Ports:
//   PCLK, PRESET          clock and synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_dir (4b H-bridge pattern, 0000 = coast), cmd_pw (24b target)
//   estop                 level-sensitive emergency stop; forces coast and zero width on the next edge
//   MOTOR, pulse_width    registered drive to the H-bridge and PWM generator
//   busy, done            busy while not IDLE; done pulses one cycle when a command completes
module motor_ramp_ctrl #(
  parameter int TICK_DIV    = 100000,
  parameter int RAMP_STEP   = 1000,
  parameter int DWELL_TICKS = 50,
  parameter int PW_MAX      = 100000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_dir,
  input  logic [23:0] cmd_pw,
  input  logic        estop,
  output logic [3:0]  MOTOR,
  output logic [23:0] pulse_width,
  output logic        busy,
  output logic        done
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
  localparam logic [24:0]   STEP25     = 25'(RAMP_STEP);
  localparam logic [24:0]   PW_MAX25   = 25'(PW_MAX);
  localparam logic [23:0]   PW_MAX24   = 24'(PW_MAX);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_DOWN = 2'd1,
    DWELL     = 2'd2,
    RAMP_UP   = 2'd3
  } state_t;

  state_t         state;
  logic [TW-1:0]  tick_cnt;
  logic [DW-1:0]  dwell_cnt;
  logic [3:0]     dir_q;
  logic [23:0]    tgt;

  logic           tick;
  logic           accept;
  logic [23:0]    cmd_tgt;

  logic [24:0]    pw_ext;
  logic [24:0]    goal;
  logic [24:0]    diff;
  logic [24:0]    step;
  logic [24:0]    pw_next;
  logic           going_down;
  logic           reach;

  assign cmd_ready = (state == IDLE) && !estop;
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (tick_cnt == TICK_LAST);

  // Target clamp; a coast command always targets zero width.
  always_comb begin
    cmd_tgt = cmd_pw;
    if (cmd_dir == 4'b0000)
      cmd_tgt = 24'd0;
    else if ({1'b0, cmd_pw} > PW_MAX25)
      cmd_tgt = PW_MAX24;
  end

  // One ramp step toward the goal, limited to the remaining distance so the
  // width lands exactly on the goal instead of overshooting or wrapping.
  always_comb begin
    pw_ext     = {1'b0, pulse_width};
    goal       = (state == RAMP_UP) ? {1'b0, tgt} : 25'd0;
    going_down = (pw_ext > goal);
    diff       = going_down ? (pw_ext - goal) : (goal - pw_ext);
    step       = (diff < STEP25) ? diff : STEP25;
    pw_next    = going_down ? (pw_ext - step) : (pw_ext + step);
    // Already at goal completes without a tick; otherwise the final step
    // completes the ramp on the same edge that lands on the goal.
    reach      = (pw_ext == goal) || (tick && (pw_next == goal));
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      MOTOR       <= 4'b0000;
      pulse_width <= 24'd0;
      done        <= 1'b0;
      tick_cnt    <= '0;
      dwell_cnt   <= '0;
      dir_q       <= 4'b0000;
      tgt         <= 24'd0;
    end else begin
      done <= 1'b0;

      // Tick phase is re-aligned to every accepted command.
      if (accept || tick)
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + 1'b1;

      if (estop) begin
        state       <= IDLE;
        MOTOR       <= 4'b0000;
        pulse_width <= 24'd0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              dir_q <= cmd_dir;
              tgt   <= cmd_tgt;
              if (cmd_dir == MOTOR) begin
                state <= RAMP_UP;
              end else if (MOTOR == 4'b0000) begin
                MOTOR <= cmd_dir;
                state <= RAMP_UP;
              end else begin
                state <= RAMP_DOWN;
              end
            end
          end

          RAMP_UP: begin
            if (reach) begin
              pulse_width <= tgt;
              state       <= IDLE;
              done        <= 1'b1;
            end else if (tick) begin
              pulse_width <= pw_next[23:0];
            end
          end

          RAMP_DOWN: begin
            if (reach) begin
              pulse_width <= 24'd0;
              MOTOR       <= 4'b0000;
              dwell_cnt   <= '0;
              if (dir_q == 4'b0000) begin
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                state <= DWELL;
              end
            end else if (tick) begin
              pulse_width <= pw_next[23:0];
            end
          end

          DWELL: begin
            if (tick) begin
              if (dwell_cnt == DWELL_LAST) begin
                MOTOR <= dir_q;
                state <= RAMP_UP;
              end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
module tb_motor_ramp_ctrl;

  logic        PCLK;
  logic        PRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_dir;
  logic [23:0] cmd_pw;
  logic        estop;
  logic [3:0]  MOTOR;
  logic [23:0] pulse_width;
  logic        busy;
  logic        done;

  motor_ramp_ctrl #(
    .TICK_DIV   (4),
    .RAMP_STEP  (10),
    .DWELL_TICKS(2),
    .PW_MAX     (100)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_pw     (cmd_pw),
    .estop      (estop),
    .MOTOR      (MOTOR),
    .pulse_width(pulse_width),
    .busy       (busy),
    .done       (done)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Inputs are held for one capture edge, then return to idle for wait_n
  // further edges; outputs are then compared.
  typedef struct packed {
    logic        pre;
    logic        vld;
    logic [3:0]  dir;
    logic [23:0] pw;
    logic [7:0]  wait_n;
    logic [3:0]  m;
    logic [23:0] p;
    logic        b;
    logic        d;
    logic        r;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   done_cnt = 0;

  always @(negedge PCLK) begin
    if (done === 1'b1) done_cnt++;
  end

  function automatic vec_t mk(input logic pre, input logic vld, input logic [3:0] dir,
                              input logic [23:0] pw, input logic [7:0] w,
                              input logic [3:0] m, input logic [23:0] p,
                              input logic b, input logic d, input logic r);
    vec_t v;
    v.pre = pre; v.vld = vld; v.dir = dir; v.pw = pw; v.wait_n = w;
    v.m = m; v.p = p; v.b = b; v.d = d; v.r = r;
    return v;
  endfunction

  task automatic edges(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic drive(input logic pre, input logic vld, input logic [3:0] dir,
                       input logic [23:0] pw, input logic es);
    PRESET = pre; cmd_valid = vld; cmd_dir = dir; cmd_pw = pw; estop = es;
  endtask

  task automatic check(input string name, input logic [3:0] em, input logic [23:0] ep,
                       input logic eb, input logic ed, input logic er);
    n_vec++;
    if (MOTOR !== em || pulse_width !== ep || busy !== eb || done !== ed || cmd_ready !== er) begin
      n_err++;
      $display("FAIL %s: got motor=%b pw=%0d busy=%b done=%b ready=%b, want motor=%b pw=%0d busy=%b done=%b ready=%b",
               name, MOTOR, pulse_width, busy, done, cmd_ready, em, ep, eb, ed, er);
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 4'b0000, 24'd0, 1'b0);

    //                pre   vld   dir      pw       wait  motor    pw       busy  done  ready
    // reset held two cycles
    tbl.push_back(mk(1'b1, 1'b0, 4'b0000, 24'd0,   8'd0, 4'b0000, 24'd0,   1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 4'b0000, 24'd0,   8'd0, 4'b0000, 24'd0,   1'b0, 1'b0, 1'b1));
    // start from coast 1010/35: MOTOR set right after accept, first step 4 cycles later
    tbl.push_back(mk(1'b0, 1'b1, 4'b1010, 24'd35,  8'd0, 4'b1010, 24'd0,   1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 24'd0,   8'd2, 4'b1010, 24'd0,   1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 24'd0,   8'd0, 4'b1010, 24'd10,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 24'd0,   8'd3, 4'b1010, 24'd20,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 24'd0,   8'd3, 4'b1010, 24'd30,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 24'd0,   8'd3, 4'b1010, 24'd35,  1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 24'd0,   8'd0, 4'b1010, 24'd35,  1'b0, 1'b0, 1'b1));
    // reversal to 0101/20: ramp down, 8-cycle dwell at coast, ramp up
    tbl.push_back(mk(1'b0, 1'b1, 4'b0101, 24'd20,  8'd0, 4'b1010, 24'd35,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 24'd0,   8'd3, 4'b1010, 24'd25,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 24'd0,   8'd3, 4'b1010, 24'd15,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 24'd0,   8'd3, 4'b1010, 24'd5,   1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 24'd0,   8'd3, 4'b0000, 24'd0,   1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 24'd0,   8'd6, 4'b0000, 24'd0,   1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 24'd0,   8'd0, 4'b0101, 24'd0,   1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 24'd0,   8'd3, 4'b0101, 24'd10,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 24'd0,   8'd3, 4'b0101, 24'd20,  1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 24'd0,   8'd0, 4'b0101, 24'd20,  1'b0, 1'b0, 1'b1));
    // clamp 1010/500 from coast to exactly 100; stale command mid-ramp ignored
    tbl.push_back(mk(1'b1, 1'b0, 4'b0000, 24'd0,   8'd0, 4'b0000, 24'd0,   1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 4'b1010, 24'd500, 8'd0, 4'b1010, 24'd0,   1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'b0101, 24'd7,   8'd3, 4'b1010, 24'd10,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 24'd0,   8'd31, 4'b1010, 24'd90, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 24'd0,   8'd3, 4'b1010, 24'd100, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 4'b0000, 24'd0,   8'd3, 4'b1010, 24'd100, 1'b0, 1'b0, 1'b1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].pre, tbl[i].vld, tbl[i].dir, tbl[i].pw, 1'b0);
      edges(1);
      drive(1'b0, 1'b0, 4'b0000, 24'd0, 1'b0);
      edges(int'(tbl[i].wait_n));
      check($sformatf("vec%0d", i), tbl[i].m, tbl[i].p, tbl[i].b, tbl[i].d, tbl[i].r);
    end

    // estop mid-ramp at pulse_width 30, with a command offered during the stop
    drive(1'b1, 1'b0, 4'b0000, 24'd0, 1'b0); edges(1);
    drive(1'b0, 1'b1, 4'b1010, 24'd80, 1'b0); edges(1);
    drive(1'b0, 1'b0, 4'b0000, 24'd0, 1'b0); edges(12);
    check("estop_pre", 4'b1010, 24'd30, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'b0101, 24'd50, 1'b1); edges(1);
    check("estop_hit", 4'b0000, 24'd0, 1'b0, 1'b0, 1'b0);
    edges(3);
    check("estop_hold", 4'b0000, 24'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'b0000, 24'd0, 1'b0); #1;
    check("estop_release", 4'b0000, 24'd0, 1'b0, 1'b0, 1'b1);
    edges(1);

    // reset in the middle of a dwell, then a fresh command from coast
    drive(1'b0, 1'b1, 4'b1010, 24'd10, 1'b0); edges(1);
    drive(1'b0, 1'b0, 4'b0000, 24'd0, 1'b0); edges(4);
    check("rd_fwd", 4'b1010, 24'd10, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 4'b0101, 24'd10, 1'b0); edges(1);
    drive(1'b0, 1'b0, 4'b0000, 24'd0, 1'b0); edges(4);
    check("rd_dwell_in", 4'b0000, 24'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'b0000, 24'd0, 1'b0); edges(1);
    drive(1'b0, 1'b0, 4'b0000, 24'd0, 1'b0);
    check("rd_reset", 4'b0000, 24'd0, 1'b0, 1'b0, 1'b1);
    edges(8);
    check("rd_stay", 4'b0000, 24'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 4'b0101, 24'd10, 1'b0); edges(1);
    drive(1'b0, 1'b0, 4'b0000, 24'd0, 1'b0);
    check("rd_new_acc", 4'b0101, 24'd0, 1'b1, 1'b0, 1'b0);
    edges(4);
    check("rd_new_done", 4'b0101, 24'd10, 1'b0, 1'b1, 1'b1);
    edges(2);

    // each completed command pulses done exactly once; the estopped one never
    n_vec++;
    if (done_cnt != 5) begin
      n_err++;
      $display("FAIL done_pulses: got %0d, want 5", done_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/motor_ramp_ctrl.md
MOTOR_RAMP_CTRL -- requirements
Module: motor_ramp_ctrl

Interface
REQ-001 SHALL have parameter `TICK_DIV`, default 100000: PCLK cycles per ramp tick.
REQ-002 SHALL have parameter `RAMP_STEP`, default 1000: maximum pulse-width change per tick.
REQ-003 SHALL have parameter `DWELL_TICKS`, default 50: ticks held with MOTOR=0000 during a reversal.
REQ-004 SHALL have parameter `PW_MAX`, default 100000: pulse-width ceiling, equal to the motor PWM period.
REQ-005 SHALL have port `PCLK`, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port `PRESET`, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port `cmd_valid`, input, 1 bit: a command is present.
REQ-008 SHALL have port `cmd_ready`, output, 1 bit: the block can accept a command.
REQ-009 SHALL have port `cmd_dir`, input, 4 bits: requested H-bridge pattern; 0000 means coast.
REQ-010 SHALL have port `cmd_pw`, input, 24 bits: requested target pulse width.
REQ-011 SHALL have port `estop`, input, 1 bit: emergency stop, level-sensitive.
REQ-012 SHALL have port `MOTOR`, output, 4 bits: registered H-bridge drive.
REQ-013 SHALL have port `pulse_width`, output, 24 bits: registered width driven to the motor PWM generator.
REQ-014 SHALL have port `busy`, output, 1 bit: high whenever state is not IDLE.
REQ-015 SHALL have port `done`, output, 1 bit: one-cycle pulse when a command completes.

Function
REQ-016 SHALL implement four states: IDLE, RAMP_DOWN, DWELL, RAMP_UP.
REQ-017 SHALL drive cmd_ready = (state==IDLE) && !estop.
REQ-018 SHALL accept a command only on a cycle where cmd_valid && cmd_ready, latching cmd_dir, and tgt = min(cmd_pw, PW_MAX), forced to 0 when cmd_dir==0000.
REQ-019 SHALL clear the tick counter on accept; tick asserts on the cycle the counter reaches TICK_DIV-1, then the counter wraps to 0, so the first tick occurs TICK_DIV cycles after accept.
REQ-020 SHALL handle same direction (cmd_dir==MOTOR, or both 0000): go to RAMP_UP, which moves toward tgt in either direction.
REQ-021 SHALL handle start from coast (MOTOR==0000, cmd_dir!=0000): set MOTOR<=cmd_dir on the cycle after accept, then RAMP_UP; no dwell.
REQ-022 SHALL handle a direction change with MOTOR!=0000 by entering RAMP_DOWN toward 0; on reaching 0, MOTOR<=0000, then:
  - if cmd_dir==0000, go to IDLE;
  - otherwise go to DWELL.
REQ-023 SHALL, in DWELL, count DWELL_TICKS ticks, then set MOTOR<=cmd_dir and enter RAMP_UP on the same cycle.
REQ-024 SHALL, on each tick in RAMP_UP/RAMP_DOWN, change pulse_width by min(RAMP_STEP, |goal-pulse_width|), where goal is tgt for RAMP_UP and 0 for RAMP_DOWN; no overshoot or underflow.
REQ-025 SHALL perform all magnitude arithmetic at 25 bits unsigned; pulse_width never exceeds PW_MAX.
REQ-026 SHALL treat a ramp with pulse_width already equal to goal as complete on the next cycle, without waiting for a tick.
REQ-027 SHALL, when RAMP_UP reaches tgt, go to IDLE and pulse done for one cycle.
REQ-028 SHALL, when RAMP_DOWN completes with cmd_dir==0000, go to IDLE and pulse done for one cycle.
REQ-029 SHALL give estop priority over everything except PRESET: on the next edge pulse_width<=0, MOTOR<=0000, state<=IDLE, done not pulsed, and any command presented that cycle is discarded.
REQ-030 SHALL ignore cmd_valid while busy; commands are not queued.
REQ-031 SHALL keep MOTOR constant during ramps; MOTOR changes only at the transitions in REQ-021, REQ-022, REQ-023 and REQ-029.

Reset
REQ-032 SHALL, on PRESET high at a rising edge, set state=IDLE, MOTOR=0000, pulse_width=0, done=0, busy=0, tick counter=0 and tgt=0, including mid-operation.
REQ-033 SHALL give PRESET priority over estop and commands.
REQ-034 SHALL drive cmd_ready=1 in the first cycle after PRESET deasserts, if estop is low.

Verification
All scenarios use TICK_DIV=4, RAMP_STEP=10, DWELL_TICKS=2, PW_MAX=100.
REQ-035 SHALL cover reset: PRESET for 2 cycles -> MOTOR=0000, pulse_width=0, busy=0, cmd_ready=1.
REQ-036 SHALL cover start from coast: cmd 1010/35 -> MOTOR=1010 one cycle after accept; pulse_width 10,20,30,35 at 4-cycle spacing; done pulse once; cmd_ready=1.
REQ-037 SHALL cover reversal: from 1010/35, cmd 0101/20 -> pulse_width 25,15,5,0; MOTOR=0000; 8 cycles dwell; MOTOR=0101; pulse_width 10,20; one done pulse.
REQ-038 SHALL cover clamp and stale command: cmd 1010/500 -> ramps to exactly 100; a second cmd_valid during the ramp is ignored and changes no output.
REQ-039 SHALL cover estop mid-ramp: estop at pulse_width=30 -> next cycle pulse_width=0, MOTOR=0000, busy=0, no done; cmd_ready=0 until estop drops.
REQ-040 SHALL cover reset mid-dwell: PRESET during DWELL -> all outputs at reset values next cycle; a new cmd 0101/10 then completes normally.
